// File: rtl/fm_audio_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : fm_audio_scheduler_if
//  Purpose  : Sample bus between the I2S side, the control plane and the
//             FM modulator.
//  Revision : 1.0  initial release
// ============================================================================
interface fm_audio_scheduler_if #(
  parameter int A  = 8,
  parameter int DW = 16
);
  logic [DW-1:0] in_data;
  logic          in_toggle;
  logic          enable;
  logic          clear_flags;
  logic [A-1:0]  audio;
  logic          audio_valid;
  logic          underrun;
  logic          overrun;
  logic [1:0]    state;

  modport master (
    output in_data, in_toggle, enable, clear_flags,
    input  audio, audio_valid, underrun, overrun, state
  );

  modport slave (
    input  in_data, in_toggle, enable, clear_flags,
    output audio, audio_valid, underrun, overrun, state
  );
endinterface
`default_nettype wire

// File: rtl/fm_audio_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fm_audio_scheduler
//  Purpose  : Toggle-handshake bridge from the I2S domain into a small FIFO,
//             releasing one sample per tick to the FM modulator.
//             Optional macro FM_SCHED_SOFTMUTE_EN ramps audio to 0 in IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module fm_audio_scheduler #(
  parameter int A        = 8,
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 1024
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fm_audio_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int TL = TICK_DIV - 1;
  localparam int HD = DEPTH / 2;
  localparam logic [AW:0]   c_DEPTH     = DEPTH[AW:0];
  localparam logic [AW:0]   c_HALF      = HD[AW:0];
  localparam logic [TW-1:0] c_TICK_LAST = TL[TW-1:0];
  localparam logic [A-1:0]  c_ONE       = {{(A-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic          r_sync1, r_sync2, r_sync3;
  logic          r_push;
  logic [A-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [TW-1:0] r_tick_cnt;
  state_t        r_state;
  logic [A-1:0]  r_audio;
  logic          r_audio_valid;
  logic          r_underrun, r_overrun;

  logic [AW:0]   w_count;
  logic          w_empty, w_full, w_tick, w_cnt_run, w_active;
  logic          w_pop, w_push_ok, w_overrun_set, w_underrun_set;
  logic [A-1:0]  w_head, w_wr_data, w_audio_mute;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == c_DEPTH);
  assign w_tick    = (r_tick_cnt == c_TICK_LAST);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_data = bus.in_data[DW-1 -: A];
  assign w_active  = bus.enable && (r_state != ST_IDLE);

  // A pop on the same edge frees a slot, so a push into a full FIFO survives.
  assign w_pop          = bus.enable && (r_state == ST_RUN) && w_tick && !w_empty;
  assign w_push_ok      = w_active && r_push && (!w_full || w_pop);
  assign w_overrun_set  = w_active && r_push && w_full && !w_pop;
  assign w_underrun_set = bus.enable && (r_state == ST_RUN) && w_tick && w_empty;

`ifdef FM_SCHED_SOFTMUTE_EN
  // Counter keeps running in IDLE until the ramp has reached zero.
  assign w_cnt_run = bus.enable || ((r_state == ST_IDLE) && (r_audio != '0));
  always_comb begin
    w_audio_mute = r_audio;
    if ((r_state == ST_IDLE) && w_tick && (r_audio != '0))
      w_audio_mute = r_audio[A-1] ? (r_audio + c_ONE) : (r_audio - c_ONE);
  end
`else
  assign w_cnt_run    = bus.enable;
  assign w_audio_mute = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_push        <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tick_cnt    <= '0;
      r_state       <= ST_IDLE;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_sync1 <= bus.in_toggle;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_push  <= r_sync2 ^ r_sync3;

      if (!w_cnt_run || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + 1'b1;

      if (!w_active) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // Set beats clear when both land on the same edge.
      if (w_underrun_set)        r_underrun <= 1'b1;
      else if (bus.clear_flags)  r_underrun <= 1'b0;
      if (w_overrun_set)         r_overrun  <= 1'b1;
      else if (bus.clear_flags)  r_overrun  <= 1'b0;

      r_audio_valid <= 1'b0;

      if (!bus.enable) begin
        r_state <= ST_IDLE;
        r_audio <= w_audio_mute;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_FILL;
            r_audio <= w_audio_mute;
          end
          ST_FILL: begin
            if (w_count >= c_HALF)
              r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_tick) begin
              if (w_empty) begin
                r_state <= ST_FILL;
              end else begin
                r_audio       <= w_head;
                r_audio_valid <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.audio       = r_audio;
  assign bus.audio_valid = r_audio_valid;
  assign bus.underrun    = r_underrun;
  assign bus.overrun     = r_overrun;
  assign bus.state       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_fm_audio_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fm_audio_scheduler
//  Purpose  : Directed self-checking bench; fast instance (TICK_DIV=8) and
//             slow instance (TICK_DIV=32) share one stimulus set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fm_audio_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_toggle = 1'b0;
  logic        enable = 1'b0;
  logic        clear_flags = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fm_audio_scheduler_if #(.A(8), .DW(16)) bus_f ();
  fm_audio_scheduler_if #(.A(8), .DW(16)) bus_s ();

  assign bus_f.in_data     = in_data;
  assign bus_f.in_toggle   = in_toggle;
  assign bus_f.enable      = enable;
  assign bus_f.clear_flags = clear_flags;
  assign bus_s.in_data     = in_data;
  assign bus_s.in_toggle   = in_toggle;
  assign bus_s.enable      = enable;
  assign bus_s.clear_flags = clear_flags;

  fm_audio_scheduler #(.A(8), .DW(16), .DEPTH(4), .TICK_DIV(8)) u_fast (
    .clk (clk), .rst (rst), .bus (bus_f)
  );
  fm_audio_scheduler #(.A(8), .DW(16), .DEPTH(4), .TICK_DIV(32)) u_slow (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data settles one cycle ahead of the toggle and is held four cycles after it.
  task automatic send(input logic [15:0] d);
    in_data = d;
    tick_n(1);
    in_toggle = ~in_toggle;
    tick_n(4);
  endtask

  task automatic hold_reset();
    rst = 1'b1; enable = 1'b0; clear_flags = 1'b0; in_toggle = 1'b0; in_data = '0;
    tick_n(3);
  endtask

  task automatic wait_valid(input bit slow, input int limit, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((slow ? bus_s.audio_valid : bus_f.audio_valid) === 1'b1) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    chk("valid_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int t1, t2;
    bit early;

    // ---- basic run, dry run, flag clear (fast) ----
    hold_reset();
    chk("rst_audio",    32'(bus_f.audio), 32'h0);
    chk("rst_valid",    32'(bus_f.audio_valid), 32'h0);
    chk("rst_underrun", 32'(bus_f.underrun), 32'h0);
    chk("rst_overrun",  32'(bus_f.overrun), 32'h0);
    chk("rst_state",    32'(bus_f.state), 32'h0);
    chk("rst_count",    32'(u_fast.w_count), 32'h0);
    rst = 1'b0; enable = 1'b1;
    send(16'h125A);
    send(16'h34C3);
    tick_n(1);
    chk("run_state", 32'(bus_f.state), 32'd2);
    chk("run_count", 32'(u_fast.w_count), 32'd2);
    wait_valid(1'b0, 20, t1);
    chk("audio_1", 32'(bus_f.audio), 32'h12);
    wait_valid(1'b0, 12, t2);
    chk("audio_2", 32'(bus_f.audio), 32'h34);
    chk("valid_gap", 32'(t2 - t1), 32'd8);
    tick_n(1);
    chk("valid_pulse", 32'(bus_f.audio_valid), 32'h0);
    tick_n(7);
    chk("dry_underrun", 32'(bus_f.underrun), 32'd1);
    chk("dry_state",    32'(bus_f.state), 32'd1);
    chk("dry_audio",    32'(bus_f.audio), 32'h34);
    clear_flags = 1'b1;
    tick_n(1);
    clear_flags = 1'b0;
    chk("clr_underrun", 32'(bus_f.underrun), 32'h0);

    // ---- overrun and push/pop on a full FIFO (slow) ----
    hold_reset();
    chk("rst_state_s", 32'(bus_s.state), 32'h0);
    rst = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 5; i++) send({8'hA0 + 8'(i), 8'h3C});
    chk("ovr_count",   32'(u_slow.w_count), 32'd4);
    chk("ovr_flag",    32'(bus_s.overrun), 32'd1);
    chk("ovr_state",   32'(bus_s.state), 32'd2);
    clear_flags = 1'b1;
    tick_n(1);
    clear_flags = 1'b0;
    chk("ovr_clear",   32'(bus_s.overrun), 32'h0);
    tick_n(1);
    send(16'hA6F0);
    chk("pp_count",    32'(u_slow.w_count), 32'd4);
    chk("pp_overrun",  32'(bus_s.overrun), 32'h0);
    chk("pp_valid",    32'(bus_s.audio_valid), 32'd1);
    chk("pp_audio_a1", 32'(bus_s.audio), 32'hA1);
    for (int i = 2; i <= 4; i++) begin
      wait_valid(1'b1, 40, t1);
      chk("seq_audio", 32'(bus_s.audio), 32'hA0 + 32'(i));
    end
    wait_valid(1'b1, 40, t1);
    chk("seq_audio_a6", 32'(bus_s.audio), 32'hA6);

    // ---- mid-run disable (fast) ----
    hold_reset();
    rst = 1'b0; enable = 1'b1;
    send(16'h0511);
    send(16'h0622);
    wait_valid(1'b0, 20, t1);
    chk("mute_pre", 32'(bus_f.audio), 32'h05);
    enable = 1'b0;
    tick_n(1);
    chk("mute_state", 32'(bus_f.state), 32'h0);
    chk("mute_count", 32'(u_fast.w_count), 32'h0);
`ifdef FM_SCHED_SOFTMUTE_EN
    chk("mute_hold", 32'(bus_f.audio), 32'h05);
    for (int v = 4; v >= 0; v--) begin
      tick_n(8);
      chk("ramp_audio", 32'(bus_f.audio), 32'(v));
      chk("ramp_valid", 32'(bus_f.audio_valid), 32'h0);
    end
`else
    chk("mute_audio", 32'(bus_f.audio), 32'h0);
`endif

    // ---- reset mid-FILL, then refill from scratch (fast) ----
    hold_reset();
    rst = 1'b0; enable = 1'b1;
    send(16'h7701);
    chk("fill_count", 32'(u_fast.w_count), 32'd1);
    chk("fill_state", 32'(bus_f.state), 32'd1);
    rst = 1'b1; in_toggle = 1'b0;
    tick_n(1);
    chk("rst2_state",    32'(bus_f.state), 32'h0);
    chk("rst2_count",    32'(u_fast.w_count), 32'h0);
    chk("rst2_audio",    32'(bus_f.audio), 32'h0);
    chk("rst2_underrun", 32'(bus_f.underrun), 32'h0);
    chk("rst2_overrun",  32'(bus_f.overrun), 32'h0);
    rst = 1'b0;
    send(16'h8802);
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_n(1);
      if (bus_f.audio_valid === 1'b1) early = 1'b1;
    end
    chk("one_sample_no_valid", 32'(early), 32'h0);
    chk("one_sample_state", 32'(bus_f.state), 32'd1);
    send(16'h9903);
    wait_valid(1'b0, 20, t1);
    chk("refill_audio", 32'(bus_f.audio), 32'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
